// File: rtl/ss_readback.sv
// ss_readback: recovers the hex word shown on the 8-digit seven-segment
// display by watching the active-low segment/digit lines, debouncing each
// digit, decoding it back to a nibble and handing the assembled word off
// over a valid/ready handshake.
module ss_readback #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic [7:0]  DIGIT_MASK    = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [7:0]  an_n,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_word,
    output logic        out_err,
    output logic        out_amb
);

    typedef enum logic {
        CAPTURE,
        VALID
    } state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [6:0]  sSeg_q;
    logic [7:0]  sAn_q;
    logic [7:0]  stableCnt_q, stableCnt_d;
    logic        taken_q, taken_d;
    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  capMask_q, capMask_d;
    logic [7:0]  errBits_q, errBits_d;
    logic [7:0]  ambBits_q, ambBits_d;

    logic        pinsLegal;
    logic        pinsSame;
    logic        accept;
    logic [6:0]  segOn;
    logic [3:0]  decNibble;
    logic        decErr;
    logic        decAmb;
    logic [2:0]  digitPos;
    logic [7:0]  digitBit;

    // The counter looks at the sample arriving on this edge against the one
    // already held, so it reads 1 on the very edge a new legal sample lands.
    assign pinsLegal = $onehot(~an_n);
    assign pinsSame  = (seg_n == sSeg_q) && (an_n == sAn_q);
    assign accept    = (stableCnt_q == STABLE) && !taken_q;
    assign digitBit  = ~sAn_q;

    // Debounce: count identical legal samples, saturate, and arm the one-shot.
    always_comb begin
        stableCnt_d = stableCnt_q;
        taken_d     = taken_q;
        if (!pinsLegal) begin
            stableCnt_d = 8'd0;
        end else if (pinsSame) begin
            if (stableCnt_q != STABLE) begin
                stableCnt_d = stableCnt_q + 8'd1;
            end
        end else begin
            stableCnt_d = 8'd1;
        end
        if (!pinsSame) begin
            taken_d = 1'b0;
        end else if (accept) begin
            taken_d = 1'b1;
        end
    end

    // Map the lit segments back to a nibble; B and D collide with 8 and 0.
    always_comb begin
        segOn     = ~sSeg_q;
        decNibble = 4'h0;
        decErr    = 1'b0;
        decAmb    = 1'b0;
        case (segOn)
            7'b0111111: begin decNibble = 4'h0; decAmb = 1'b1; end
            7'b0000110: decNibble = 4'h1;
            7'b1011011: decNibble = 4'h2;
            7'b1001111: decNibble = 4'h3;
            7'b1100110: decNibble = 4'h4;
            7'b1101101: decNibble = 4'h5;
            7'b1111101: decNibble = 4'h6;
            7'b0000111: decNibble = 4'h7;
            7'b1111111: begin decNibble = 4'h8; decAmb = 1'b1; end
            7'b1101111: decNibble = 4'h9;
            7'b1110111: decNibble = 4'hA;
            7'b0111001: decNibble = 4'hC;
            7'b1111001: decNibble = 4'hE;
            7'b1110001: decNibble = 4'hF;
            default:    decErr = 1'b1;
        endcase
    end

    // Which nibble slot the held digit enable points at.
    always_comb begin
        digitPos = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!sAn_q[k]) begin
                digitPos = 3'(k);
            end
        end
    end

    // Word assembly and the CAPTURE/VALID handshake controller.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        capMask_d = capMask_q;
        errBits_d = errBits_q;
        ambBits_d = ambBits_q;
        case (state_q)
            CAPTURE: begin
                if (accept) begin
                    word_d[{digitPos, 2'b00} +: 4] = decNibble;
                    capMask_d = capMask_q | digitBit;
                    errBits_d = (errBits_q & ~digitBit) | (decErr ? digitBit : 8'h00);
                    ambBits_d = (ambBits_q & ~digitBit) | (decAmb ? digitBit : 8'h00);
                    if ((capMask_d & DIGIT_MASK) == DIGIT_MASK) begin
                        state_d = VALID;
                    end
                end
            end
            VALID: begin
                if (out_ready) begin
                    state_d   = CAPTURE;
                    capMask_d = 8'h00;
                    errBits_d = 8'h00;
                    ambBits_d = 8'h00;
                end
            end
            default: state_d = CAPTURE;
        endcase
    end

    // State registers; reset wins over everything and drops any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sSeg_q      <= 7'h7F;
            sAn_q       <= 8'hFF;
            stableCnt_q <= 8'd0;
            taken_q     <= 1'b0;
            state_q     <= CAPTURE;
            word_q      <= 32'h0;
            capMask_q   <= 8'h00;
            errBits_q   <= 8'h00;
            ambBits_q   <= 8'h00;
        end else begin
            sSeg_q      <= seg_n;
            sAn_q       <= an_n;
            stableCnt_q <= stableCnt_d;
            taken_q     <= taken_d;
            state_q     <= state_d;
            word_q      <= word_d;
            capMask_q   <= capMask_d;
            errBits_q   <= errBits_d;
            ambBits_q   <= ambBits_d;
        end
    end

    assign out_valid = (state_q == VALID);
    assign out_word  = word_q;
    assign out_err   = |(errBits_q & DIGIT_MASK);
    assign out_amb   = |(ambBits_q & DIGIT_MASK);

endmodule

// File: tb/tb_ss_readback.sv
// tb_ss_readback: directed checks of the seven-segment readback decoder.
// Three instances share the display pins: the default build, a two-digit
// mask build and a single-cycle debounce build.
module tb_ss_readback;

    localparam logic [6:0] P0 = 7'h3F;
    localparam logic [6:0] P1 = 7'h06;
    localparam logic [6:0] P2 = 7'h5B;
    localparam logic [6:0] P3 = 7'h4F;
    localparam logic [6:0] P4 = 7'h66;
    localparam logic [6:0] P5 = 7'h6D;
    localparam logic [6:0] P6 = 7'h7D;
    localparam logic [6:0] P7 = 7'h07;
    localparam logic [6:0] P8 = 7'h7F;
    localparam logic [6:0] P9 = 7'h6F;
    localparam logic [6:0] PA = 7'h77;
    localparam logic [6:0] PC = 7'h39;
    localparam logic [6:0] PE = 7'h79;
    localparam logic [6:0] PF = 7'h71;
    localparam logic [6:0] PBLANK = 7'h00;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic        out_ready;

    logic        validM, errM, ambM;
    logic [31:0] wordM;
    logic        validP, errP, ambP;
    logic [31:0] wordP;
    logic        valid1, err1, amb1;
    logic [31:0] word1;

    int          testsRun;
    int          testsFailed;
    int          validCount;
    logic [31:0] lastWord;
    logic        lastErr;
    logic        lastAmb;
    int          vcStart;

    ss_readback #(.STABLE_CYCLES(4), .DIGIT_MASK(8'hFF)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .out_ready(out_ready),
        .out_valid(validM), .out_word(wordM), .out_err(errM), .out_amb(ambM)
    );

    ss_readback #(.STABLE_CYCLES(4), .DIGIT_MASK(8'h03)) dutP (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .out_ready(out_ready),
        .out_valid(validP), .out_word(wordP), .out_err(errP), .out_amb(ambP)
    );

    ss_readback #(.STABLE_CYCLES(1), .DIGIT_MASK(8'h01)) dut1 (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n), .out_ready(out_ready),
        .out_valid(valid1), .out_word(word1), .out_err(err1), .out_amb(amb1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every cycle the default instance presents a word.
    initial begin
        validCount = 0;
        lastWord   = 32'h0;
        lastErr    = 1'b0;
        lastAmb    = 1'b0;
    end
    always @(negedge clk) begin
        if (validM === 1'b1) begin
            validCount <= validCount + 1;
            lastWord   <= wordM;
            lastErr    <= errM;
            lastAmb    <= ambM;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Show an active-high pattern on digit k and hold it for the given edges.
    task automatic applyStimulus(input int k, input logic [6:0] pattern, input int cycles);
        logic [7:0] sel;
        sel   = 8'h01 << k;
        an_n  = ~sel;
        seg_n = ~pattern;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic idlePins();
        an_n  = 8'hFF;
        seg_n = 7'h7F;
    endtask

    task automatic doReset();
        rst   = 1'b1;
        seg_n = 7'($urandom);
        an_n  = 8'($urandom);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idlePins();
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        out_ready   = 1'b0;
        rst         = 1'b1;
        seg_n       = 7'($urandom);
        an_n        = 8'($urandom);

        // Reset with random pins, then idle for the debounce window.
        repeat (2) @(negedge clk);
        checkOutput("rstValid", 32'(validM), 32'd0);
        checkOutput("rstWord", wordM, 32'h0);
        checkOutput("rstErr", 32'(errM), 32'd0);
        checkOutput("rstAmb", 32'(ambM), 32'd0);
        checkOutput("rstValidP", 32'(validP), 32'd0);
        checkOutput("rstValid1", 32'(valid1), 32'd0);
        rst = 1'b0;
        idlePins();
        repeat (4) @(negedge clk);
        checkOutput("idleValid", 32'(validM), 32'd0);
        checkOutput("idleCount", 32'(validCount), 32'd0);
        checkOutput("idleWord", wordM, 32'h0);

        // Latency: single-cycle build writes one edge after the sample,
        // default build on the fourth edge after it.
        applyStimulus(0, P5, 1);
        checkOutput("lat1Edge0", word1, 32'h0);
        checkOutput("lat1Valid0", 32'(valid1), 32'd0);
        @(negedge clk);
        checkOutput("lat1Edge1", word1, 32'h5);
        checkOutput("lat1Valid1", 32'(valid1), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("latMEdge3", wordM, 32'h0);
        @(negedge clk);
        checkOutput("latMEdge4", wordM, 32'h5);

        // Debounce: a 3-cycle glitch of 5 is ignored, a 4-cycle 6 is taken.
        doReset();
        applyStimulus(0, P5, 3);
        applyStimulus(0, P6, 4);
        checkOutput("dbGlitch", wordM, 32'h0);
        idlePins();
        repeat (2) @(negedge clk);
        checkOutput("dbNibble", wordM, 32'h6);

        // Full word 0x1234ABCF shown on the display, consumer always ready.
        doReset();
        out_ready = 1'b1;
        vcStart   = validCount;
        applyStimulus(0, PF, 6);
        applyStimulus(1, PC, 6);
        applyStimulus(2, P8, 6);
        applyStimulus(3, PA, 6);
        applyStimulus(4, P4, 6);
        applyStimulus(5, P3, 6);
        applyStimulus(6, P2, 6);
        applyStimulus(7, P1, 6);
        checkOutput("fwCount", 32'(validCount - vcStart), 32'd1);
        checkOutput("fwWord", lastWord, 32'h1234A8CF);
        checkOutput("fwAmb", 32'(lastAmb), 32'd1);
        checkOutput("fwErr", 32'(lastErr), 32'd0);
        checkOutput("fwValidAfter", 32'(validM), 32'd0);

        // Two enables low at once are ignored entirely.
        an_n  = 8'hFC;
        seg_n = ~P5;
        repeat (6) @(negedge clk);
        checkOutput("multiAn", wordM, 32'h1234A8CF);

        // Blank digit 0 decodes to 0 and flags the emitted word as errored.
        vcStart = validCount;
        applyStimulus(0, PBLANK, 6);
        checkOutput("blankNibble", wordM, 32'h1234A8C0);
        applyStimulus(1, P1, 6);
        applyStimulus(2, P2, 6);
        applyStimulus(3, P3, 6);
        applyStimulus(4, P4, 6);
        applyStimulus(5, P5, 6);
        applyStimulus(6, P6, 6);
        applyStimulus(7, P7, 6);
        checkOutput("errCount", 32'(validCount - vcStart), 32'd1);
        checkOutput("errWord", lastWord, 32'h76543210);
        checkOutput("errFlag", 32'(lastErr), 32'd1);
        checkOutput("errAmb", 32'(lastAmb), 32'd0);

        // Backpressure: word held while the display keeps changing.
        out_ready = 1'b0;
        doReset();
        applyStimulus(0, P5, 6);
        applyStimulus(1, P6, 6);
        applyStimulus(2, PA, 6);
        applyStimulus(3, P7, 6);
        applyStimulus(4, PE, 6);
        applyStimulus(5, P9, 6);
        applyStimulus(6, PF, 6);
        applyStimulus(7, P3, 6);
        checkOutput("bpRise", 32'(validM), 32'd1);
        for (int g = 0; g < 4; g++) begin
            an_n  = ~(8'h01 << g);
            seg_n = ~P8;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                checkOutput("bpValid", 32'(validM), 32'd1);
                checkOutput("bpWord", wordM, 32'h3F9E7A65);
            end
        end
        idlePins();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bpFall", 32'(validM), 32'd0);
        applyStimulus(0, P1, 6);
        checkOutput("bpFresh", wordM, 32'h3F9E7A61);
        checkOutput("bpFreshValid", 32'(validM), 32'd0);

        // Two-digit mask: digits 0 and 1 alone complete a word.
        doReset();
        applyStimulus(0, P7, 6);
        applyStimulus(1, P9, 6);
        checkOutput("pmValid", 32'(validP), 32'd1);
        checkOutput("pmWord", 32'(wordP[7:0]), 32'h97);
        checkOutput("pmErr", 32'(errP), 32'd0);
        checkOutput("pmAmb", 32'(ambP), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("pmFall", 32'(validP), 32'd0);

        // Reset after digit 0 discards it; both digits must come again.
        doReset();
        applyStimulus(0, P7, 6);
        doReset();
        applyStimulus(1, P9, 6);
        checkOutput("mrNoValid", 32'(validP), 32'd0);
        checkOutput("mrWord", 32'(wordP[7:0]), 32'h90);
        applyStimulus(0, P7, 6);
        checkOutput("mrValid", 32'(validP), 32'd1);
        checkOutput("mrWordDone", 32'(wordP[7:0]), 32'h97);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
